sorter_datapath: RTL

Storage and arithmetic half of the in-place exchange sorter. Holds the SIZE-entry element memory, the three index counters (cnt, cnt_i, cnt_j), the two operand registers and the comparator. Driven cycle by cycle by the sorter controller's load/enable/select strobes, it returns the counter values and compare result the controller branches on, and emits the sorted stream during readout.

---
 rtl/sorter_pkg.sv | 20 ++
 rtl/sorter_if.sv | 34 +++
 rtl/sorter_index_counter.sv | 28 ++
 rtl/sorter_datapath.sv | 111 +++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared definitions for the exchange-sorter datapath: counter width helper and
// the select encodings used by the address and write-data muxes.
package sorter_pkg;

  // Counters need one extra bit so they can reach SIZE at the end of a pass.
  function automatic int calc_aw(input int size);
    return $clog2(size) + 1;
  endfunction

  // Address select, encoded as {s1, s0}; s0 is ignored when s1=0.
  localparam logic [1:0] ADDR_CNT = 2'b00;
  localparam logic [1:0] ADDR_I   = 2'b10;
  localparam logic [1:0] ADDR_J   = 2'b11;

  // Write-data select, encoded as {s3, s2}; s2 is ignored when s3=0.
  localparam logic [1:0] WD_DIN   = 2'b00;
  localparam logic [1:0] WD_A     = 2'b10;
  localparam logic [1:0] WD_B     = 2'b11;

endpackage

// File: rtl/sorter_if.sv
// Strobe/status bundle between the sorter controller (master) and the
// datapath (slave).
interface sorter_if
  import sorter_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int DW   = 8
);
  localparam int AW = calc_aw(SIZE);

  logic [DW-1:0] din;
  logic          load_cnt, load_cnti, load_cntj;
  logic          ena_cnt, ena_cnti, ena_cntj;
  logic          en_rega, en_regb;
  logic          we, re;
  logic          s0, s1, s2, s3;
  logic [AW-1:0] cnt, cnt_i, cnt_j;
  logic          result_cmp;
  logic [DW-1:0] dout;
  logic          dout_valid;

  modport master (
    output din, load_cnt, load_cnti, load_cntj, ena_cnt, ena_cnti, ena_cntj,
           en_rega, en_regb, we, re, s0, s1, s2, s3,
    input  cnt, cnt_i, cnt_j, result_cmp, dout, dout_valid
  );

  modport slave (
    input  din, load_cnt, load_cnti, load_cntj, ena_cnt, ena_cnti, ena_cntj,
           en_rega, en_regb, we, re, s0, s1, s2, s3,
    output cnt, cnt_i, cnt_j, result_cmp, dout, dout_valid
  );

endinterface

// File: rtl/sorter_index_counter.sv
// Loadable index counter: ena gates all updates, load picks load_value over +1.
// Wraps modulo 2^AW.
module sorter_index_counter #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          load,
  input  logic [AW-1:0] load_value,
  output logic [AW-1:0] cnt
);

  logic [AW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (ena) cnt_d = load ? load_value : cnt_q + AW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sorter_datapath.sv
// Element memory, index counters, operand registers and comparator of the
// exchange sorter. Define SORTER_DESCENDING_EN to flip the compare (descending sort).
module sorter_datapath
  import sorter_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int DW   = 8
) (
  input  logic    clk,
  input  logic    rst,
  sorter_if.slave bus
);

  localparam int AW = calc_aw(SIZE);
  localparam int IW = AW - 1;

  logic [AW-1:0]          cnt, cnt_i, cnt_j;
  logic [AW-1:0]          addr;
  logic [IW-1:0]          idx;
  logic [1:0]             addr_sel, wd_sel;
  logic [DW-1:0]          wdata, rdata;
  logic [SIZE-1:0][DW-1:0] mem_d, mem_q;
  logic [DW-1:0]          rega_d, rega_q, regb_d, regb_q;
  logic [DW-1:0]          dout_d, dout_q;
  logic                   dout_valid_d, dout_valid_q;
  logic                   readout;

  sorter_index_counter #(.AW(AW)) u_cnt (
    .clk(clk), .rst(rst), .ena(bus.ena_cnt), .load(bus.load_cnt),
    .load_value('0), .cnt(cnt)
  );

  sorter_index_counter #(.AW(AW)) u_cnt_i (
    .clk(clk), .rst(rst), .ena(bus.ena_cnti), .load(bus.load_cnti),
    .load_value('0), .cnt(cnt_i)
  );

  // Inner-loop start is always one past the current outer index.
  sorter_index_counter #(.AW(AW)) u_cnt_j (
    .clk(clk), .rst(rst), .ena(bus.ena_cntj), .load(bus.load_cntj),
    .load_value(cnt_i + AW'(1)), .cnt(cnt_j)
  );

  always_comb begin
    addr_sel = bus.s1 ? {1'b1, bus.s0} : ADDR_CNT;
    case (addr_sel)
      ADDR_I:  addr = cnt_i;
      ADDR_J:  addr = cnt_j;
      default: addr = cnt;
    endcase
  end

  always_comb begin
    wd_sel = bus.s3 ? {1'b1, bus.s2} : WD_DIN;
    case (wd_sel)
      WD_A:    wdata = rega_q;
      WD_B:    wdata = regb_q;
      default: wdata = bus.din;
    endcase
  end

  // cnt=SIZE aliases to entry 0 here; the controller never writes in that state.
  assign idx   = addr[IW-1:0];
  assign rdata = mem_q[idx];

  always_comb begin
    mem_d = mem_q;
    if (bus.we) mem_d[idx] = wdata;
  end

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign readout = bus.re && !bus.s1;

  always_comb begin
    rega_d       = bus.en_rega ? rdata : rega_q;
    regb_d       = bus.en_regb ? rdata : regb_q;
    dout_d       = readout ? rdata : dout_q;
    dout_valid_d = readout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rega_q       <= '0;
      regb_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rega_q       <= rega_d;
      regb_q       <= regb_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef SORTER_DESCENDING_EN
  assign bus.result_cmp = (rega_q < regb_q);
`else
  assign bus.result_cmp = (rega_q > regb_q);
`endif

  assign bus.cnt        = cnt;
  assign bus.cnt_i      = cnt_i;
  assign bus.cnt_j      = cnt_j;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule
